// File: rtl/swd_host.sv
// swd_host -- SWD initiator bit engine (debug-probe side).
//
// Takes one DP/AP register access per command, shifts out the 8-bit request,
// turns the line around, samples the 3-bit ACK and then runs the read or write
// data phase (32 bits LSB first plus parity). A driven-low idle tail follows
// every transaction. Completion is a one-CLK RSP_VALID pulse carrying the ACK,
// the read word and a read-parity error flag.
//
// Parameters:
//   CLKDIV      CLK cycles per SWDCLK half-period (1..255)
//   TURN        turnaround length in bit periods (1..4)
//   IDLE_CYCLES driven-low idle bit periods after each transaction (0..255)
//
// Ports:
//   CLK, PORESETn            system clock, async active-low reset
//   CMD_VALID/CMD_READY      command handshake
//   CMD_APnDP, CMD_RnW,
//   CMD_ADDR, CMD_WDATA      access descriptor, registered on acceptance
//   RSP_VALID                one-CLK completion pulse
//   RSP_ACK/RDATA/PERR       completion status, held until the next pulse
//   SWDCLK                   SWD clock, idles low
//   SWDOUT/SWDOUTEN/SWDIN    SWDIO output, output enable, input
//
// Optional feature (macro SWD_LINE_RESET_EN): adds input CMD_LRST; a command
// accepted with CMD_LRST=1 drives 56 bit periods of SWDIO high (line reset)
// followed by the idle tail, completing with all-zero response fields.

module swd_host #(
  parameter int unsigned CLKDIV      = 4,
  parameter int unsigned TURN        = 1,
  parameter int unsigned IDLE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        PORESETn,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_APnDP,
  input  logic        CMD_RnW,
  input  logic [1:0]  CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
`ifdef SWD_LINE_RESET_EN
  input  logic        CMD_LRST,
`endif
  output logic        RSP_VALID,
  output logic [2:0]  RSP_ACK,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_PERR,
  output logic        SWDCLK,
  output logic        SWDOUT,
  output logic        SWDOUTEN,
  input  logic        SWDIN
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_TRN1,
    S_ACK,
    S_RDATA,
    S_TRN2,
    S_WDATA,
    S_TAIL
`ifdef SWD_LINE_RESET_EN
    , S_LRST
`endif
  } state_t;

  state_t      state;
  logic [7:0]  div_cnt;
  logic [7:0]  bit_cnt;
  logic [7:0]  bit_len;
  logic [7:0]  req_sh;
  logic [2:0]  ack_r;
  logic [31:0] data_sh;
  logic [31:0] wdata_r;
  logic        rnw_r;
  logic        par_in;

  logic        half_done;
  logic        bit_end;
  logic        last_bit;
  logic        ack_ok;
  logic        wr_ok;
  logic        rd_ok;
  logic        to_tail;
  logic        finish;
  logic        req_par;

  assign req_par = CMD_APnDP ^ CMD_RnW ^ CMD_ADDR[0] ^ CMD_ADDR[1];

  always_comb begin
    bit_len = 8'd1;
    case (state)
      S_REQ:           bit_len = 8'd8;
      S_TRN1, S_TRN2:  bit_len = 8'(TURN);
      S_ACK:           bit_len = 8'd3;
      S_RDATA,
      S_WDATA:         bit_len = 8'd33;
      S_TAIL:          bit_len = 8'(IDLE_CYCLES);
`ifdef SWD_LINE_RESET_EN
      S_LRST:          bit_len = 8'd56;
`endif
      default:         bit_len = 8'd1;
    endcase
  end

  assign half_done = (div_cnt == 8'(CLKDIV - 1));
  assign bit_end   = (state != S_IDLE) && half_done && SWDCLK;
  assign last_bit  = (bit_cnt == bit_len - 8'd1);
  assign ack_ok    = (ack_r == 3'b001);
  assign wr_ok     = ack_ok && !rnw_r;
  assign rd_ok     = ack_ok && rnw_r;

  // States whose last bit hands over to the idle tail.
  always_comb begin
    to_tail = ((state == S_TRN2) && !wr_ok) || (state == S_WDATA);
`ifdef SWD_LINE_RESET_EN
    to_tail = to_tail || (state == S_LRST);
`endif
  end

  // Tail end, or a tail hand-over when the tail has zero length, completes
  // the command; this overrides the per-state update below.
  assign finish = bit_end && last_bit &&
                  ((state == S_TAIL) || (to_tail && (IDLE_CYCLES == 0)));

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      req_sh    <= '0;
      ack_r     <= '0;
      data_sh   <= '0;
      wdata_r   <= '0;
      rnw_r     <= 1'b0;
      par_in    <= 1'b0;
      CMD_READY <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_ACK   <= '0;
      RSP_RDATA <= '0;
      RSP_PERR  <= 1'b0;
      SWDCLK    <= 1'b0;
      SWDOUT    <= 1'b0;
      SWDOUTEN  <= 1'b1;
    end else begin
      RSP_VALID <= 1'b0;
      if (RSP_VALID) CMD_READY <= 1'b1;

      if (state == S_IDLE) begin
        if (CMD_VALID && CMD_READY) begin
          CMD_READY <= 1'b0;
          div_cnt   <= '0;
          bit_cnt   <= '0;
          ack_r     <= '0;
          rnw_r     <= CMD_RnW;
          wdata_r   <= CMD_WDATA;
          // Wire order LSB first: 1, APnDP, RnW, A2, A3, P, 0, 1.
          req_sh    <= {1'b1, 1'b0, req_par, CMD_ADDR[1], CMD_ADDR[0],
                        CMD_RnW, CMD_APnDP, 1'b1};
          SWDOUT    <= 1'b1;
          SWDOUTEN  <= 1'b1;
          state     <= S_REQ;
`ifdef SWD_LINE_RESET_EN
          if (CMD_LRST) state <= S_LRST;
`endif
        end
      end else if (!half_done) begin
        div_cnt <= div_cnt + 8'd1;
      end else begin
        div_cnt <= '0;
        if (!SWDCLK) begin
          // Rising SWDCLK: sample the target.
          SWDCLK <= 1'b1;
          if (state == S_ACK) ack_r <= {SWDIN, ack_r[2:1]};
          if (state == S_RDATA) begin
            if (bit_cnt == 8'd32) par_in  <= SWDIN;
            else                  data_sh <= {SWDIN, data_sh[31:1]};
          end
        end else begin
          // Falling SWDCLK: end of bit, drive the next one.
          SWDCLK  <= 1'b0;
          bit_cnt <= last_bit ? 8'd0 : bit_cnt + 8'd1;
          case (state)
            S_REQ: begin
              if (last_bit) begin
                state    <= S_TRN1;
                SWDOUT   <= 1'b0;
                SWDOUTEN <= 1'b0;
              end else begin
                SWDOUT <= req_sh[1];
                req_sh <= req_sh >> 1;
              end
            end
            S_TRN1: if (last_bit) state <= S_ACK;
            S_ACK: if (last_bit) state <= rd_ok ? S_RDATA : S_TRN2;
            S_RDATA: if (last_bit) state <= S_TRN2;
            S_TRN2: begin
              if (last_bit) begin
                if (wr_ok) begin
                  state    <= S_WDATA;
                  SWDOUTEN <= 1'b1;
                  SWDOUT   <= wdata_r[0];
                  data_sh  <= wdata_r;
                end else begin
                  state    <= S_TAIL;
                  SWDOUT   <= 1'b0;
                  SWDOUTEN <= 1'b1;
                end
              end
            end
            S_WDATA: begin
              if (last_bit) begin
                state    <= S_TAIL;
                SWDOUT   <= 1'b0;
                SWDOUTEN <= 1'b1;
              end else if (bit_cnt == 8'd31) begin
                SWDOUT <= ^wdata_r;
              end else begin
                SWDOUT  <= data_sh[1];
                data_sh <= data_sh >> 1;
              end
            end
`ifdef SWD_LINE_RESET_EN
            S_LRST: begin
              if (last_bit) begin
                state    <= S_TAIL;
                SWDOUT   <= 1'b0;
                SWDOUTEN <= 1'b1;
              end
            end
`endif
            default: ;
          endcase

          if (finish) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            SWDOUT    <= 1'b0;
            SWDOUTEN  <= 1'b1;
            RSP_VALID <= 1'b1;
            RSP_ACK   <= ack_r;
            RSP_RDATA <= rd_ok ? data_sh : '0;
            RSP_PERR  <= rd_ok && (par_in != ^data_sh);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_swd_host.sv
module tb_swd_host;

  localparam int unsigned CLKDIV      = 4;
  localparam int unsigned TURN        = 1;
  localparam int unsigned IDLE_CYCLES = 2;

  logic        CLK = 1'b0;
  logic        PORESETn = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_APnDP = 1'b0;
  logic        CMD_RnW = 1'b0;
  logic [1:0]  CMD_ADDR = '0;
  logic [31:0] CMD_WDATA = '0;
`ifdef SWD_LINE_RESET_EN
  logic        CMD_LRST = 1'b0;
`endif
  logic        RSP_VALID;
  logic [2:0]  RSP_ACK;
  logic [31:0] RSP_RDATA;
  logic        RSP_PERR;
  logic        SWDCLK;
  logic        SWDOUT;
  logic        SWDOUTEN;
  logic        SWDIN = 1'b0;

  swd_host #(
    .CLKDIV      (CLKDIV),
    .TURN        (TURN),
    .IDLE_CYCLES (IDLE_CYCLES)
  ) dut (
    .CLK       (CLK),
    .PORESETn  (PORESETn),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_APnDP (CMD_APnDP),
    .CMD_RnW   (CMD_RnW),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_WDATA (CMD_WDATA),
`ifdef SWD_LINE_RESET_EN
    .CMD_LRST  (CMD_LRST),
`endif
    .RSP_VALID (RSP_VALID),
    .RSP_ACK   (RSP_ACK),
    .RSP_RDATA (RSP_RDATA),
    .RSP_PERR  (RSP_PERR),
    .SWDCLK    (SWDCLK),
    .SWDOUT    (SWDOUT),
    .SWDOUTEN  (SWDOUTEN),
    .SWDIN     (SWDIN)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference wire schedule, one entry per bit period.
  bit exp_oe[$];
  bit exp_out[$];
  bit tin[$];
  bit got_oe[$];
  bit got_out[$];

  logic [7:0] last_req;
  bit         have_prev = 0;
  logic [2:0] prev_ack;

  task automatic push(input bit oe, input bit out, input bit ti);
    exp_oe.push_back(oe);
    exp_out.push_back(out);
    tin.push_back(ti);
  endtask

  task automatic build(input bit lrst, input bit ap, input bit rnw, input logic [1:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input logic [2:0] ack,
                       input bit rpar);
    logic [7:0] req;
    exp_oe.delete(); exp_out.delete(); tin.delete();
    if (lrst) begin
      for (int i = 0; i < 56; i++) push(1, 1, 1'($urandom_range(0, 1)));
    end else begin
      req = {1'b1, 1'b0, ap ^ rnw ^ a[0] ^ a[1], a[1], a[0], rnw, ap, 1'b1};
      for (int i = 0; i < 8; i++) push(1, req[i], 0);
      for (int i = 0; i < TURN; i++) push(0, 0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 3; i++) push(0, 0, ack[i]);
      if (ack == 3'b001 && rnw) begin
        for (int i = 0; i < 32; i++) push(0, 0, rd[i]);
        push(0, 0, rpar);
        for (int i = 0; i < TURN; i++) push(0, 0, 0);
      end else if (ack == 3'b001) begin
        for (int i = 0; i < TURN; i++) push(0, 0, 0);
        for (int i = 0; i < 32; i++) push(1, wd[i], 0);
        push(1, ^wd, 0);
      end else begin
        for (int i = 0; i < TURN; i++) push(0, 0, 0);
      end
    end
    for (int i = 0; i < IDLE_CYCLES; i++) push(1, 0, 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_lvl(input logic lvl, output bit to);
    to = 1;
    for (int i = 0; i < 4 * CLKDIV + 4; i++) begin
      @(negedge CLK);
      if (SWDCLK === lvl) begin
        to = 0;
        break;
      end
    end
  endtask

  task automatic run(input bit lrst, input bit ap, input bit rnw, input logic [1:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input logic [2:0] ack,
                     input bit rpar, input int abort_at);
    bit          rd_ok, to, seen;
    logic [2:0]  eack;
    logic [31:0] erd;
    bit          eperr;
    int unsigned acc, n_bits, mism, oe_low, exp_low, base, vcnt;
    logic [32:0] wseen;

    build(lrst, ap, rnw, a, wd, rd, ack, rpar);
    rd_ok  = !lrst && ack == 3'b001 && rnw;
    eack   = lrst ? 3'b000 : ack;
    erd    = rd_ok ? rd : 32'h0;
    eperr  = rd_ok && (rpar != ^rd);
    n_bits = exp_oe.size();

    @(negedge CLK);
    check("ready_idle", CMD_READY, 1);
    check("idle_line", {SWDCLK, SWDOUT, SWDOUTEN}, 3'b001);
    if (have_prev) check("rsp_hold", RSP_ACK, prev_ack);
    SWDIN     = tin[0];
    CMD_APnDP = ap;
    CMD_RnW   = rnw;
    CMD_ADDR  = a;
    CMD_WDATA = wd;
`ifdef SWD_LINE_RESET_EN
    CMD_LRST  = lrst;
`endif
    CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
`ifdef SWD_LINE_RESET_EN
    CMD_LRST  = 1'b0;
`endif
    acc = cyc;
    check("ready_busy", CMD_READY, 0);

    got_oe.delete(); got_out.delete();
    to = 0;
    for (int n = 0; n < n_bits; n++) begin
      SWDIN = tin[n];
      wait_lvl(1'b1, to);
      if (to) break;
      got_oe.push_back(SWDOUTEN);
      got_out.push_back(SWDOUT);
      if (n == abort_at) begin
        #2 PORESETn = 1'b0;
        #1;
        check("rst_outs", {CMD_READY, RSP_VALID, RSP_ACK, RSP_PERR, SWDCLK, SWDOUT, SWDOUTEN},
              9'b1_0_000_0_0_0_1);
        check("rst_rdata", RSP_RDATA, 0);
        @(negedge CLK);
        PORESETn = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 500; i++) begin
          @(negedge CLK);
          if (RSP_VALID) vcnt++;
        end
        check("abort_no_rsp", vcnt, 0);
        have_prev = 0;
        return;
      end
      if (n == 2) begin
        // Command offered while busy must be ignored entirely.
        CMD_APnDP = 1'($urandom_range(0, 1));
        CMD_RnW   = 1'($urandom_range(0, 1));
        CMD_ADDR  = 2'($urandom_range(0, 3));
        CMD_WDATA = $urandom;
        CMD_VALID = 1'b1;
        @(negedge CLK);
        check("busy_ignored", CMD_READY, 0);
        CMD_VALID = 1'b0;
      end
      if (n != n_bits - 1) begin
        wait_lvl(1'b0, to);
        if (to) break;
      end
    end
    check("swdclk_timeout", to, 0);
    if (to) return;

    mism = 0;
    oe_low = 0;
    if (got_oe.size() != n_bits) mism++;
    for (int i = 0; i < n_bits && i < got_oe.size(); i++) begin
      if (got_oe[i] != exp_oe[i]) mism++;
      else if (exp_oe[i] && got_out[i] != exp_out[i]) mism++;
      if (!got_oe[i]) oe_low++;
    end
    check("wire", mism, 0);
    exp_low = lrst ? 0 : (rd_ok ? 2 * TURN + 36 : 2 * TURN + 3);
    check("oe_low_bits", oe_low, exp_low);
    for (int i = 0; i < 8; i++) last_req[i] = got_out[i];
    if (!lrst && ack == 3'b001 && !rnw) begin
      base = 8 + TURN + 3 + TURN;
      for (int i = 0; i < 33; i++) wseen[i] = got_out[base + i];
      check("wdata_seen", wseen[31:0], wd);
      check("wpar_seen", wseen[32], ^wd);
    end

    seen = 0;
    for (int i = 0; i < 64; i++) begin
      if (RSP_VALID === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge CLK);
    end
    check("rsp_timeout", seen, 1);
    if (!seen) return;
    check("latency", cyc - acc, n_bits * 2 * CLKDIV);
    check("rsp_ack", RSP_ACK, eack);
    check("rsp_rdata", RSP_RDATA, erd);
    check("rsp_perr", RSP_PERR, eperr);
    check("ready_at_rsp", CMD_READY, 0);
    @(negedge CLK);
    check("rsp_pulse", RSP_VALID, 0);
    check("ready_after", CMD_READY, 1);
    have_prev = 1;
    prev_ack  = eack;
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  ack_tab [6];
    logic [31:0] rd;
    ack_tab = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b111, 3'b000};

    #2 PORESETn = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_outs", {CMD_READY, RSP_VALID, RSP_ACK, RSP_PERR, SWDCLK, SWDOUT, SWDOUTEN},
          9'b1_0_000_0_0_0_1);
    check("reset_rdata", RSP_RDATA, 0);
    PORESETn = 1'b1;
    repeat (2) @(negedge CLK);

    // DP read addr 0
    run(0, 0, 1, 2'b00, 32'h0, 32'h2BA01477, 3'b001, 1'b0, -1);
    check("req_dp_rd", last_req, 8'hA5);
    // AP write addr 1
    run(0, 1, 0, 2'b01, 32'h12345678, 32'h0, 3'b001, 1'b0, -1);
    check("req_ap_wr", last_req, 8'h8B);
    // WAIT, FAULT, protocol error
    run(0, 0, 1, 2'b10, 32'h0, 32'hDEADBEEF, 3'b010, 1'b0, -1);
    run(0, 1, 0, 2'b11, 32'hCAFEF00D, 32'h0, 3'b100, 1'b0, -1);
    run(0, 1, 1, 2'b01, 32'h0, 32'h0, 3'b111, 1'b0, -1);
    // Bad read parity
    run(0, 0, 1, 2'b11, 32'h0, 32'h00000001, 3'b001, 1'b0, -1);
    // Reset during RDATA, then a normal read
    run(0, 1, 1, 2'b00, 32'h0, 32'hA5A5F00F, 3'b001, 1'b0, 8 + TURN + 3 + 10);
    run(0, 1, 1, 2'b10, 32'h0, 32'h0BADC0DE, 3'b001, 1'b0, -1);

    for (int t = 0; t < 12; t++) begin
      rd = $urandom;
      run(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          $urandom, rd, ack_tab[$urandom_range(0, 5)],
          (^rd) ^ ($urandom_range(0, 3) == 0), -1);
    end

`ifdef SWD_LINE_RESET_EN
    run(1, 1, 1, 2'b11, 32'hFFFFFFFF, 32'h0, 3'b000, 1'b0, -1);
    run(0, 0, 1, 2'b00, 32'h0, 32'h2BA01477, 3'b001, 1'b0, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/swd_host.md
Name: swd_host

Overview:
- SWD initiator (debug-probe side) that drives SWDCLK/SWDIO toward a Cortex-M SWD target port, such as flexsoc_cm3's TCK_SWDCLK/TMS_SWDIN/SWDOUT/SWDOUTEN pins.
- Accepts one DP/AP register access per command, serialises the request packet, handles turnaround, ACK and the data phase, then returns ACK, read data and a parity-error flag.
- Used by the host-side transport as the bit engine behind the UART bridge, and in simulation as the active stimulus for the target's SWD port.

Parameters:
- CLKDIV, 4: CLK cycles per SWDCLK half-period. Legal range 1..255.
- TURN, 1: turnaround length in SWD bit periods. Legal range 1..4.
- IDLE_CYCLES, 2: bit periods of driven-low idle appended after every transaction. Legal range 0..255.

Ports:
- CLK  in  1  system clock
- PORESETn  in  1  asynchronous active-low reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  engine idle; a command is accepted when CMD_VALID & CMD_READY
- CMD_APnDP  in  1  1=AP access, 0=DP access
- CMD_RnW  in  1  1=read, 0=write
- CMD_ADDR  in  2  A[3:2]
- CMD_WDATA  in  32  write data
- RSP_VALID  out  1  one-CLK completion pulse
- RSP_ACK  out  3  ACK as received; bit0 is the first bit on the wire
- RSP_RDATA  out  32  read data; 0 for writes and non-OK ACKs
- RSP_PERR  out  1  read-data parity mismatch
- SWDCLK  out  1  SWD clock
- SWDOUT  out  1  SWDIO output value
- SWDOUTEN  out  1  SWDIO output enable; the tristate is external
- SWDIN  in  1  SWDIO input

Behaviour:
- Reset values: CMD_READY=1, RSP_VALID=0, RSP_ACK=0, RSP_RDATA=0, RSP_PERR=0, SWDCLK=0, SWDOUT=0, SWDOUTEN=1.
- Async reset mid-operation aborts the transfer immediately. No RSP_VALID is issued for the aborted command.
- Command capture:
  - All CMD_* fields are registered on acceptance.
  - CMD_READY=0 from the next cycle until the cycle after the RSP_VALID pulse.
- Bit timing:
  - Each bit period is 2*CLKDIV CLK cycles, with SWDCLK low for the first half and high for the second.
  - SWDOUT/SWDOUTEN change only at the start of a low half.
  - SWDIN is sampled on the CLK edge that drives SWDCLK high.
  - SWDCLK idles low; no clocks are issued while in IDLE.
- FSM: IDLE -> REQ(8) -> TRN1(TURN) -> ACK(3), then:
  - ACK=001 and read: RDATA(33) -> TRN2(TURN) -> TAIL(IDLE_CYCLES) -> IDLE.
  - ACK=001 and write: TRN2(TURN) -> WDATA(33) -> TAIL -> IDLE.
  - Any other ACK (WAIT 010, FAULT 100, or protocol error such as 111/000): TRN2(TURN) -> TAIL -> IDLE. There is no data phase.
- REQ bits, in wire order: 1, APnDP, RnW, A2, A3, P, 0, 1.
  - P = XOR of APnDP, RnW, A2, A3.
- SWDOUTEN:
  - 0 during TRN1, ACK, RDATA and the read TRN2.
  - 0 during the TRN2 for non-OK ACKs.
  - 0 during the write TRN2.
  - 1 otherwise.
- Data phase: 32 data bits LSB first, then parity = XOR of the 32 bits.
  - WDATA: parity is driven by the host.
  - RDATA: parity is checked; RSP_PERR=1 on mismatch, and RSP_RDATA still holds the received word.
- TAIL drives SWDOUT=0. With IDLE_CYCLES=0, TAIL is skipped.
- RSP_VALID:
  - Pulses for exactly one CLK in the cycle after the last bit period ends.
  - RSP_* outputs hold their values until the next RSP_VALID.
  - CMD_READY returns to 1 in the following cycle.
- CMD_VALID while busy is ignored; the command is not queued.
- Latency with defaults (TURN=1, IDLE_CYCLES=2, CLKDIV=4):
  - Read and write both take 48 bit periods = 384 CLK from acceptance to RSP_VALID.
  - WAIT/FAULT takes 15 bit periods = 120 CLK.

Optional Feature:
- Macro: SWD_LINE_RESET_EN.
- With the macro defined:
  - Adds input CMD_LRST (1 bit).
  - An accepted command with CMD_LRST=1 performs a line reset: 56 bit periods of SWDOUT=1, SWDOUTEN=1, followed by TAIL.
  - The other CMD_* fields are ignored.
  - RSP_VALID pulses with RSP_ACK=0, RSP_RDATA=0, RSP_PERR=0.
- Without the macro: the CMD_LRST port and the line-reset state do not exist.

Test Plan:
- DP read addr 0 (APnDP=0, RnW=1, A=00); target returns ACK 001 and data 0x2BA01477 with parity 0.
  - REQ wire bits 1,0,1,0,0,1,0,1 (0xA5 LSB-first).
  - RSP_ACK=001, RSP_RDATA=0x2BA01477, RSP_PERR=0.
  - RSP_VALID exactly 384 CLK after acceptance.
- AP write addr 1, WDATA=0x12345678, ACK 001.
  - REQ bits 1,1,0,1,0,0,0,1.
  - Target observes 0x12345678 followed by parity 1.
  - SWDOUTEN=0 during exactly TURN+3+TURN bit periods.
- Read with ACK 010 (WAIT).
  - No data phase; RSP_ACK=010, RSP_RDATA=0.
  - RSP_VALID 120 CLK after acceptance.
- Read returning 0x00000001 with parity bit 0.
  - RSP_PERR=1, RSP_RDATA=0x00000001.
- PORESETn asserted during the RDATA phase.
  - All outputs return to reset values asynchronously.
  - No RSP_VALID; the next command executes normally.
- (SWD_LINE_RESET_EN) CMD_LRST=1.
  - 56 high bit periods, then 2 low bit periods.
  - RSP_VALID with RSP_ACK=000.
